// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter and sequencer in front of the
// single-port main memory. Each grant runs IDLE -> ACCESS -> RESP, so one
// ram access completes every three cycles and the winner sees a one-cycle ack.
module ram_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_wr_en,
    output logic                  ram_rd_en,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  busy
);
    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    state_t                               state_q, state_d;
    logic   [NUM_PORTS-1:0]               req_vec;
    req_t   [NUM_PORTS-1:0]               port_req;
    req_t                                 cur_q;
    logic                                 id_q;
    logic                                 last_grant;
    logic                                 win;
    logic                                 take;
    logic   [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_q;
    logic   [NUM_PORTS-1:0]               ack_vec;

    assign req_vec     = {m1_req, m0_req};
    assign port_req[0] = {m0_we, m0_addr, m0_wdata};
    assign port_req[1] = {m1_we, m1_addr, m1_wdata};

    // A lone requester wins; on a tie the port that did not win last goes.
    assign win = (&req_vec) ? ~last_grant : req_vec[1];

    // Next-state: accept a request only from IDLE, then one ACCESS and one RESP.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_vec) begin
                    state_d = ACCESS;
                    take    = 1'b1;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, grant history and the latched transaction of the current winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            cur_q      <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                id_q  <= win;
                cur_q <= port_req[win];
            end
            if (state_q == RESP) last_grant <= id_q;
        end
    end

    // Read data lands in the winner's register at the edge closing ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (state_q == ACCESS && !cur_q.we) begin
            rdata_q[id_q] <= ram_data_out;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_ack
        assign ack_vec[p] = (state_q == RESP) && (id_q == 1'(p));
    end

    assign m0_ack   = ack_vec[0];
    assign m1_ack   = ack_vec[1];
    assign m0_rdata = rdata_q[0];
    assign m1_rdata = rdata_q[1];

    // Strobes are gated by rst so a reset landing in ACCESS commits nothing.
    assign ram_addr    = cur_q.addr;
    assign ram_data_in = cur_q.wdata;
    assign ram_wr_en   = (state_q == ACCESS) &  cur_q.we & ~rst;
    assign ram_rd_en   = (state_q == ACCESS) & ~cur_q.we & ~rst;
    assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios plus randomized two-port traffic, checked
// against a transaction-level model (grant edge, commit edge, release edge).
module tb_ram_arbiter;
    localparam int DW = 16;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m0_ack, m1_ack, ram_wr_en, ram_rd_en, busy;
    logic [DW-1:0] m0_rdata, m1_rdata, ram_data_in, ram_data_out;
    logic [AW-1:0] ram_addr;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_wr_en(ram_wr_en),
        .ram_rd_en(ram_rd_en), .ram_data_out(ram_data_out), .busy(busy)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'(i * 37 + 16'h1111);
    endfunction

    // Main memory stand-in; a junk pattern when not read so stray captures show.
    logic [DW-1:0] mem [4096];
    logic          mem_init = 1'b1;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
        end else if (ram_wr_en) begin
            mem[ram_addr] <= ram_data_in;
        end
    end
    assign ram_data_out = ram_rd_en ? mem[ram_addr] : 16'hDEAD;

    // Reference model state
    logic [DW-1:0]        ref_mem [4096];
    bit                   pend;
    int                   g_edge;
    bit                   p_id, p_we;
    logic [AW-1:0]        p_addr, exp_addr;
    logic [DW-1:0]        p_wdata, exp_din;
    bit                   last_win = 1'b1;
    logic [1:0][DW-1:0]   exp_rd = '0;
    int                   cyc = 0;
    int                   checks = 0, errors = 0;
    bit                   seen0, seen1, hold_req = 1'b0;
    logic [DW-1:0]        seen_rd0, seen_rd1;
    int                   wr_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance the model by one edge using the inputs the DUT just sampled.
    task automatic model_edge();
        cyc++;
        if (rst) begin
            pend = 0; last_win = 1'b1; exp_rd = '0; exp_addr = '0; exp_din = '0;
        end else if (pend && cyc == g_edge + 1) begin
            if (p_we) ref_mem[p_addr] = p_wdata;
            else      exp_rd[p_id]    = ref_mem[p_addr];
        end else if (pend && cyc == g_edge + 2) begin
            pend = 0; last_win = p_id;
        end else if (!pend && (m0_req || m1_req)) begin
            p_id    = (m0_req && m1_req) ? !last_win : m1_req;
            p_we    = p_id ? m1_we    : m0_we;
            p_addr  = p_id ? m1_addr  : m0_addr;
            p_wdata = p_id ? m1_wdata : m0_wdata;
            exp_addr = p_addr; exp_din = p_wdata;
            g_edge = cyc; pend = 1;
        end
    endtask

    task automatic check_outputs();
        bit acc, rsp;
        acc = pend && cyc == g_edge;
        rsp = pend && cyc == g_edge + 1;
        chk("ack0",     32'(m0_ack),            32'(rsp && !p_id));
        chk("ack1",     32'(m1_ack),            32'(rsp && p_id));
        chk("one_ack",  32'(m0_ack & m1_ack),   32'(0));
        chk("busy",     32'(busy),              32'(acc || rsp));
        chk("wr_en",    32'(ram_wr_en),         32'(acc && p_we && !rst));
        chk("rd_en",    32'(ram_rd_en),         32'(acc && !p_we && !rst));
        chk("ram_addr", 32'(ram_addr),          32'(exp_addr));
        chk("ram_din",  32'(ram_data_in),       32'(exp_din));
        chk("rdata0",   32'(m0_rdata),          32'(exp_rd[0]));
        chk("rdata1",   32'(m1_rdata),          32'(exp_rd[1]));
    endtask

    // One clock: model, sample #1 after the edge, then return at the negedge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        seen0 = m0_ack; seen1 = m1_ack;
        seen_rd0 = m0_rdata; seen_rd1 = m1_rdata;
        if (ram_wr_en) wr_cnt++;
        @(negedge clk);
        if (!hold_req) begin
            if (seen0) m0_req = 1'b0;
            if (seen1) m1_req = 1'b0;
        end
    endtask

    task automatic set_port(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p) begin m1_we = we; m1_addr = a; m1_wdata = d; m1_req = 1'b1; end
        else   begin m0_we = we; m0_addr = a; m0_wdata = d; m0_req = 1'b1; end
    endtask

    // Issue one request and wait (bounded) for its ack; reports latency.
    task automatic do_req(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [DW-1:0] rd, output int lat);
        int start;
        bit done;
        start = cyc; done = 0; rd = '0; lat = -1;
        set_port(p, we, a, d);
        for (int n = 0; n < 20 && !done; n++) begin
            tick();
            if (p ? seen1 : seen0) begin
                done = 1; lat = cyc - start; rd = p ? seen_rd1 : seen_rd0;
            end
        end
        if (!done) chk("req_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        logic [DW-1:0] rd;
        int            lat, a0, a1;
        int            order [$];

        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);

        // Reset held two cycles: everything quiet.
        tick(); tick();
        chk("rst_ack0", 32'(m0_ack), 32'(0));   chk("rst_ack1", 32'(m1_ack), 32'(0));
        chk("rst_rd0", 32'(m0_rdata), 32'(0));  chk("rst_rd1", 32'(m1_rdata), 32'(0));
        chk("rst_addr", 32'(ram_addr), 32'(0)); chk("rst_din", 32'(ram_data_in), 32'(0));
        chk("rst_wr", 32'(ram_wr_en), 32'(0));  chk("rst_rden", 32'(ram_rd_en), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        rst = 1'b0; mem_init = 1'b0;

        // Tie fairness with both reads held high: first goes to port 0, then alternate.
        hold_req = 1'b1;
        set_port(0, 0, 12'h100, 16'h0);
        set_port(1, 0, 12'h200, 16'h0);
        for (int i = 0; i < 40 && order.size() < 4; i++) begin
            tick();
            if (seen0) order.push_back(0);
            if (seen1) order.push_back(1);
        end
        m0_req = 1'b0; m1_req = 1'b0; hold_req = 1'b0;
        chk("tie_count", 32'(order.size()), 32'(4));
        for (int i = 0; i < order.size() && i < 4; i++) chk("tie_order", 32'(order[i]), 32'(i % 2));
        tick();

        // Port 0 write then read back.
        wr_cnt = 0;
        do_req(0, 1, 12'h123, 16'hBEEF, rd, lat);
        chk("w_latency", 32'(lat), 32'(2));
        chk("w_pulses", 32'(wr_cnt), 32'(1));
        tick();
        do_req(0, 0, 12'h123, 16'h0, rd, lat);
        chk("r_latency", 32'(lat), 32'(2));
        chk("r_data", 32'(rd), 32'(16'hBEEF));
        tick();

        // Boundary addresses on port 1; port 0 read data must stay put.
        do_req(1, 1, 12'hFFF, 16'h1234, rd, lat); tick();
        do_req(1, 1, 12'h000, 16'h5678, rd, lat); tick();
        do_req(1, 0, 12'hFFF, 16'h0, rd, lat);    tick();
        chk("bnd_fff", 32'(rd), 32'(16'h1234));
        do_req(1, 0, 12'h000, 16'h0, rd, lat);    tick();
        chk("bnd_000", 32'(rd), 32'(16'h5678));
        chk("bnd_m0_hold", 32'(m0_rdata), 32'(16'hBEEF));

        // Reset landing in ACCESS: write is dropped, no ack.
        do_req(1, 1, 12'h010, 16'h5555, rd, lat); tick();
        set_port(1, 1, 12'h010, 16'hAAAA);
        tick();
        rst = 1'b1;
        #1 chk("rst_wr_mask", 32'(ram_wr_en), 32'(0));
        tick();
        rst = 1'b0; m1_req = 1'b0;
        a1 = 0;
        for (int i = 0; i < 4; i++) begin tick(); if (seen1) a1++; end
        chk("rst_no_ack", 32'(a1), 32'(0));
        do_req(1, 0, 12'h010, 16'h0, rd, lat); tick();
        chk("rst_prior", 32'(rd), 32'(16'h5555));

        // Late request from port 1 while port 0 is in ACCESS.
        set_port(0, 0, 12'h123, 16'h0);
        tick();
        set_port(1, 0, 12'h000, 16'h0);
        a0 = -1; a1 = -1;
        for (int i = 0; i < 20 && a1 < 0; i++) begin
            tick();
            if (seen0) a0 = cyc;
            if (seen1) a1 = cyc;
        end
        chk("late_seen", 32'(a0 > 0 && a1 > 0), 32'(1));
        chk("late_gap", 32'(a1 - a0), 32'(3));
        tick();

        // Randomized traffic, including early req drop after grant.
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < 2; p++) begin
                bit            r, s, we;
                logic [AW-1:0] a;
                r  = p ? m1_req : m0_req;
                s  = p ? seen1 : seen0;
                we = 1'($urandom_range(0, 1));
                a  = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'(12'hFF8 + $urandom_range(0, 7));
                if (!r && !s && $urandom_range(0, 2) == 0) begin
                    set_port(1'(p), we, a, DW'($urandom));
                end else if (r && pend && p_id == 1'(p) && $urandom_range(0, 7) == 0) begin
                    if (p) m1_req = 1'b0; else m0_req = 1'b0;
                end
            end
            tick();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
